// File: rtl/neuron_delay_pkg.sv
// ============================================================================
// neuron_delay_pkg : shared defaults and helpers for the spike delay array
// Rev 1.0
// ============================================================================
`default_nettype none

package neuron_delay_pkg;

    localparam int N_CH_DEFAULT = 8;
    localparam int DW_DEFAULT   = 3;
    localparam int MERGE_CNT_W  = 16;

    function automatic int max_delay(input int dw);
        return (1 << dw) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_delay_lane.sv
// ============================================================================
// neuron_delay_lane : one channel's delay register, pending bit and shift line
// Rev 1.0
// ============================================================================
`default_nettype none

module neuron_delay_lane
    import neuron_delay_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          delay_en,
    input  logic          wr,
    input  logic [DW-1:0] cfg_delay,
    input  logic          din,
    output logic          dout,
    output logic          merge
);

    localparam int MAX_DELAY = max_delay(DW);

    logic [DW-1:0]        d;
    logic                 pend;
    logic [MAX_DELAY-1:0] line;
    logic [MAX_DELAY:0]   line_ext;
    logic                 active;
    logic                 s;

    assign active   = delay_en && (d != '0);
    assign s        = pend | din;
    assign line_ext = {line, s};
    // A second pulse before the next tick folds into the already pending spike
    assign merge    = active && !wr && pend && din;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            d    <= '0;
            pend <= 1'b0;
            line <= '0;
            dout <= 1'b0;
        end else if (wr) begin
            d    <= cfg_delay;
            pend <= 1'b0;
            line <= '0;
            dout <= 1'b0;
        end else if (!active) begin
            pend <= 1'b0;
            line <= '0;
            dout <= din;
        end else if (tick) begin
            dout <= line[d - 1'b1];
            line <= line_ext[MAX_DELAY-1:0];
            pend <= 1'b0;
        end else begin
            pend <= s;
            dout <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/neuron_delay_array.sv
// ============================================================================
// neuron_delay_array : N_CH-channel synaptic delay line with config decode
// Optional merged-spike counter under NEURON_DELAY_MERGE_CNT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module neuron_delay_array
    import neuron_delay_pkg::*;
#(
    parameter  int N_CH = N_CH_DEFAULT,
    parameter  int DW   = DW_DEFAULT,
    localparam int AW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   delay,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [DW-1:0]          cfg_delay,
    input  logic [N_CH-1:0]        din,
    output logic [N_CH-1:0]        dout
`ifdef NEURON_DELAY_MERGE_CNT_EN
    ,
    output logic [MERGE_CNT_W-1:0] merge_cnt
`endif
);

    logic [N_CH-1:0] merges;

    // Addresses at or beyond N_CH match no lane and are silently dropped
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        neuron_delay_lane #(.DW(DW)) u_lane (
            .sys_clk   (sys_clk),
            .reset     (reset),
            .tick      (tick),
            .delay_en  (delay),
            .wr        (cfg_we && (cfg_addr == AW'(i))),
            .cfg_delay (cfg_delay),
            .din       (din[i]),
            .dout      (dout[i]),
            .merge     (merges[i])
        );
    end

`ifdef NEURON_DELAY_MERGE_CNT_EN
    localparam int SUM_W = $clog2(N_CH + 1);

    logic [SUM_W-1:0]     merge_sum;
    logic [MERGE_CNT_W:0] cnt_sum;

    always_comb begin
        merge_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            merge_sum = merge_sum + SUM_W'(merges[i]);
        end
        cnt_sum = {1'b0, merge_cnt} + (MERGE_CNT_W + 1)'(merge_sum);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            merge_cnt <= '0;
        end else begin
            merge_cnt <= cnt_sum[MERGE_CNT_W] ? '1 : cnt_sum[MERGE_CNT_W-1:0];
        end
    end
`else
    logic unused_merge;
    assign unused_merge = ^merges;
`endif

endmodule

`default_nettype wire

// File: tb/tb_neuron_delay_array.sv
// ============================================================================
// tb_neuron_delay_array : directed scenarios plus random traffic vs tick-time model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neuron_delay_array;

    localparam int N_CH = 6;
    localparam int DW   = 3;
    localparam int AW   = 3;

    logic            sys_clk = 1'b0;
    logic            reset   = 1'b1;
    logic            tick    = 1'b0;
    logic            delay   = 1'b0;
    logic            cfg_we  = 1'b0;
    logic [AW-1:0]   cfg_addr  = '0;
    logic [DW-1:0]   cfg_delay = '0;
    logic [N_CH-1:0] din  = '0;
    logic [N_CH-1:0] dout;
`ifdef NEURON_DELAY_MERGE_CNT_EN
    logic [15:0]     merge_cnt;
`endif

    always #5 sys_clk = ~sys_clk;

    neuron_delay_array #(.N_CH(N_CH), .DW(DW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .tick      (tick),
        .delay     (delay),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_delay (cfg_delay),
        .din       (din),
        .dout      (dout)
`ifdef NEURON_DELAY_MERGE_CNT_EN
        ,
        .merge_cnt (merge_cnt)
`endif
    );

    // Reference: each in-flight spike is the absolute tick index at which it leaves
    int              md    [N_CH];
    bit              mpend [N_CH];
    int              q     [N_CH][$];
    int              tnow;
    logic [N_CH-1:0] exp_dout;
    int              exp_merge;
    int              pc    [N_CH];
    int              vectors = 0;
    int              errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            md[ch]    = 0;
            mpend[ch] = 1'b0;
            q[ch].delete();
        end
        tnow      = 0;
        exp_dout  = '0;
        exp_merge = 0;
    endtask

    task automatic model_step();
        logic [N_CH-1:0] nxt;
        nxt = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (cfg_we && (int'(cfg_addr) == ch)) begin
                md[ch] = int'(cfg_delay);
                mpend[ch] = 1'b0;
                q[ch].delete();
            end else if (!delay || md[ch] == 0) begin
                nxt[ch] = din[ch];
                mpend[ch] = 1'b0;
                q[ch].delete();
            end else begin
                if (mpend[ch] && din[ch]) exp_merge++;
                if (tick) begin
                    if (q[ch].size() > 0 && q[ch][0] == tnow) begin
                        nxt[ch] = 1'b1;
                        void'(q[ch].pop_front());
                    end
                    if (mpend[ch] || din[ch]) q[ch].push_back(tnow + md[ch]);
                    mpend[ch] = 1'b0;
                end else begin
                    mpend[ch] = mpend[ch] | din[ch];
                end
            end
        end
        if (tick) tnow++;
        if (exp_merge > 65535) exp_merge = 65535;
        exp_dout = nxt;
    endtask

    task automatic cycle(input logic t, input logic [N_CH-1:0] d);
        tick = t;
        din  = d;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check("dout", 32'(dout), 32'(exp_dout));
`ifdef NEURON_DELAY_MERGE_CNT_EN
        check("merge_cnt", 32'(merge_cnt), 32'(exp_merge));
`endif
        for (int ch = 0; ch < N_CH; ch++) pc[ch] += int'(dout[ch]);
        tick   = 1'b0;
        din    = '0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input int ch, input int dv);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(ch);
        cfg_delay = DW'(dv);
        cycle(1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("async_reset_dout", 32'(dout), 32'd0);
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
    endtask

    task automatic clear_pc();
        for (int ch = 0; ch < N_CH; ch++) pc[ch] = 0;
    endtask

    initial begin
        int hit;
        model_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        check("reset_dout", 32'(dout), 32'd0);

        // d[0]=4, tick every 3 cycles: released one cycle after the 4th following tick
        delay = 1'b1;
        cfg(0, 4);
        hit = -1;
        for (int c = 0; c < 20; c++) begin
            cycle((c % 3) == 0, (c == 0) ? 6'b000001 : 6'b0);
            if (dout[0] && hit < 0) hit = c;
        end
        check("s1_release_cycle", 32'(hit), 32'd12);

        // bypass on a zero-delay channel and with delay disabled
        cycle(1'b0, 6'b000100);
        cycle(1'b1, 6'b0);
        delay = 1'b0;
        cycle(1'b1, 6'b000101);
        cycle(1'b0, 6'b0);
        delay = 1'b1;

        // d[1]=7 with tick held high: five back-to-back spikes, none lost
        cfg(1, 7);
        clear_pc();
        for (int c = 0; c < 20; c++) cycle(1'b1, (c < 5) ? 6'b000010 : 6'b0);
        check("s3_burst_count", 32'(pc[1]), 32'd5);

        // three pulses between ticks on d[3]=2 collapse into one spike
        do_reset();
        delay = 1'b1;
        cfg(3, 2);
        cycle(1'b1, '0);
        clear_pc();
        repeat (3) cycle(1'b0, 6'b001000);
        for (int c = 0; c < 8; c++) cycle((c % 2) == 0, '0);
        check("s4_merged_count", 32'(pc[3]), 32'd1);
`ifdef NEURON_DELAY_MERGE_CNT_EN
        check("s4_merge_cnt", 32'(merge_cnt), 32'd2);
`endif

        // rewrite of ch5 coincident with a tick discards the in-flight spike
        cfg(5, 6);
        cycle(1'b1, 6'b100000);
        cycle(1'b1, '0);
        clear_pc();
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_delay = 3'd2;
        cycle(1'b1, 6'b100000);
        cfg(6, 1);
        cfg(7, 3);
        cycle(1'b1, 6'b100000);
        for (int c = 0; c < 24; c++) cycle((c % 2) == 0, '0);
        check("s5_ch5_count", 32'(pc[5]), 32'd1);

        // spikes in flight everywhere, then reset and a delay 1->0->1 toggle
        for (int ch = 0; ch < N_CH; ch++) cfg(ch, ch + 1);
        cycle(1'b1, '1);
        cycle(1'b0, '1);
        do_reset();
        clear_pc();
        for (int c = 0; c < 20; c++) cycle(1'b1, '0);
        check("s6_after_reset", 32'(pc[0] + pc[1] + pc[2] + pc[3] + pc[4] + pc[5]), 32'd0);
        delay = 1'b1;
        for (int ch = 0; ch < N_CH; ch++) cfg(ch, 7 - ch);
        cycle(1'b1, '1);
        cycle(1'b1, '1);
        delay = 1'b0;
        cycle(1'b0, '0);
        delay = 1'b1;
        clear_pc();
        for (int c = 0; c < 20; c++) cycle(1'b1, '0);
        check("s6_after_toggle", 32'(pc[0] + pc[1] + pc[2] + pc[3] + pc[4] + pc[5]), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) delay = ~delay;
            if ($urandom_range(0, 699) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) begin
                cfg_we    = 1'b1;
                cfg_addr  = AW'($urandom_range(0, 7));
                cfg_delay = DW'($urandom_range(0, 7));
            end
            cycle($urandom_range(0, 2) == 0, N_CH'($urandom & $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/neuron_delay_array.md
# neuron_delay_array

Parametrised, multi-channel synaptic delay line for the spiking front end of the keyword-spotting network. Each of N_CH spike channels has its own programmable delay of 0..2^DW-1 delay ticks, with multiple spikes in flight per channel. Time advances on a single-cycle tick strobe in the sys_clk domain, so no second clock is needed. The block sits between the spike encoder/previous layer and the neuron integrators.

## Interface
- N_CH, 8: number of independent spike channels (≥1)
- DW, 3: delay field width; MAX_DELAY = 2^DW-1 ticks (localparam)
- AW, $clog2(N_CH) (min 1): config address width (localparam)

Clock and reset: one clock; reset is asynchronous and active-high.
- sys_clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous active-high reset
- tick  in  1  single-cycle delay-time strobe
- delay  in  1  global delay enable; 0 = all channels bypass
- cfg_we  in  1  write strobe for one channel's delay
- cfg_addr  in  AW  channel index; writes with cfg_addr ≥ N_CH are ignored
- cfg_delay  in  DW  delay value in ticks
- din  in  N_CH  input spikes, one-cycle pulses
- dout  out  N_CH  output spikes, registered one-cycle pulses
- merge_cnt  out  16  merged-spike counter (only with NEURON_DELAY_MERGE_CNT_EN)

## Operation
- Per channel: delay register d[ch] (DW bits), pending bit pend[ch], shift line line[ch] of MAX_DELAY bits.
- Reset: all d = 0, pend = 0, line = 0, dout = 0, merge_cnt = 0.
- Sample s[ch] = pend[ch] | din[ch].
- Bypass (delay = 0 or d[ch] = 0): dout[ch] <= din[ch] every cycle; tick has no effect. pend[ch] and line[ch] are held at 0.
- Delayed mode (delay = 1 and d[ch] ≥ 1):
  - Non-tick cycle: pend[ch] <= s[ch]; dout[ch] <= 0.
  - Tick cycle: dout[ch] <= line[ch][d[ch]-1] (pre-shift value); line[ch] <= {line[ch][MAX_DELAY-2:0], s[ch]}; pend[ch] <= 0.
- Multiple din pulses on one channel between two ticks merge into one spike. A merge is a din pulse arriving while pend[ch] is already 1.
- Config write (cfg_we, valid address): d[cfg_addr] <= cfg_delay. On the same cycle, line and pend of that channel are cleared and dout of that channel is 0. The write takes priority over a coincident tick, and the din pulse on that cycle is dropped. Other channels are unaffected.
- delay falling 1→0: all lines and pend bits are cleared on the next edge, so no stale spikes are released. delay rising 0→1: lines start empty.

## Timing
- Bypass latency: 1 sys_clk (dout at cycle after din).
- Delayed latency: a spike sampled at tick k appears on dout in the cycle after tick k+d[ch]. The pulse is exactly one cycle wide.
- A din pulse in the same cycle as tick k counts as sampled at tick k. A pulse in the cycle after tick k is sampled at tick k+1.
- Back-to-back ticks (tick held high) are legal: each cycle is one tick.
- Spike density: one spike per channel per tick; line holds up to MAX_DELAY spikes, no loss except merges.
- Reset asserted mid-operation: all in-flight spikes are discarded immediately (async). Outputs are 0 until the first post-reset event.

## Configuration
- NEURON_DELAY_MERGE_CNT_EN defined:
  - merge_cnt counts merge events summed over all channels per cycle, saturating at 16'hFFFF.
  - Reset clears the counter; config writes do not.
- Not defined: merge_cnt port and counter logic are absent; merges are silent.

## Structure
- Package neuron_delay_pkg: default N_CH/DW constants, MAX_DELAY function, merge counter width constant (16).
- One sub-module natural: neuron_delay_lane holds one channel's d, pend, line and output mux. The top instantiates N_CH lanes plus config decode and the optional merge counter.

## Test plan
- Reset, then delay=1, d[0]=4, din[0] pulse on a tick cycle, tick every 3 cycles → dout[0] pulse one cycle after the 4th following tick (cycle 13 relative to sampling tick). All other dout stay 0.
- d[2]=0 or delay=0 → din[2] pulse at cycle t gives dout[2] at t+1, independent of tick.
- d[1]=7, spikes on 5 consecutive ticks with tick held high → 5 consecutive dout[1] pulses starting 7 ticks later; no loss.
- Three din[3] pulses between two ticks, d[3]=2 → single dout[3] pulse; merge_cnt = 2 with NEURON_DELAY_MERGE_CNT_EN.
- Spike in flight on ch5 (d=6), cfg_we to ch5 with d=2 coincident with a tick → no dout[5] pulse ever from that spike; next spike delayed 2 ticks. cfg_addr ≥ N_CH is ignored.
- Reset pulse with spikes in flight on all channels → all dout 0, no delayed pulses after release; delay 1→0→1 also releases nothing.
